// File: rtl/ghostbus_pkg.sv
// ghostbus_pkg: shared constants for the ghostbus register block.
// Holds the CSR word addresses, the RAM window base, the default ID
// value and the CTRL bit positions used by ghostbus_top.
package ghostbus_pkg;

    localparam logic [23:0] ADDR_ID      = 24'h000000;
    localparam logic [23:0] ADDR_SCRATCH = 24'h000001;
    localparam logic [23:0] ADDR_CTRL    = 24'h000002;
    localparam logic [23:0] ADDR_COUNT   = 24'h000003;
    localparam logic [23:0] ADDR_STATUS  = 24'h000004;
    localparam logic [23:0] RAM_BASE     = 24'h000100;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h47425553;

    // CTRL register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

endpackage

// File: rtl/ghostbus_ram.sv
// ghostbus_ram: single-port synchronous RAM, (2^AW) x DW.
// One write port and one registered read port. A read and a write to the
// same word on the same edge return the old contents (read-before-write).
// The read register only loads on a read, so it holds its value between
// reads. Contents and read register are deliberately not reset.
module ghostbus_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage write and registered read; NBA ordering gives read-before-write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ghostbus_top.sv
// ghostbus_top: ghostbus register block endpoint.
// Decodes a word address into ID/SCRATCH/CTRL/COUNT/STATUS CSRs and an
// optional RAM window. Writes take effect on the strobe edge; reads return
// registered data one cycle after the strobe and hold until the next read.
// Optional feature macro: GHOSTBUS_RAM_EN (instantiates the RAM window;
// without it the window reads 0 and ignores writes).
module ghostbus_top
    import ghostbus_pkg::*;
#(
    parameter int            AW       = 24,
    parameter int            DW       = 32,
    parameter int            RAM_AW   = 8,
    parameter logic [31:0]   ID_VALUE = ghostbus_pkg::ID_VALUE_DEFAULT,
    parameter logic [AW-1:0] RAM_BASE = AW'(ghostbus_pkg::RAM_BASE)
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic [AW-1:0] gb_addr,
    input  logic [DW-1:0] gb_wdata,
    input  logic          gb_wen,
    input  logic          gb_rstb,
    output logic [DW-1:0] gb_rdata
);

    logic [DW-1:0] scratch_q;
    logic [7:0]    ctrl_q;
    logic [31:0]   count_q;
    logic          ovf_q;
    logic [DW-1:0] csr_rdata_q;
    logic [DW-1:0] rd_mux;

    logic sel_id, sel_scratch, sel_ctrl, sel_count, sel_status, sel_ram;
    logic wr_ctrl, cnt_clr, cnt_inc, cnt_wrap, status_w1c;

    // Full-width address decode
    assign sel_id      = (gb_addr == AW'(ADDR_ID));
    assign sel_scratch = (gb_addr == AW'(ADDR_SCRATCH));
    assign sel_ctrl    = (gb_addr == AW'(ADDR_CTRL));
    assign sel_count   = (gb_addr == AW'(ADDR_COUNT));
    assign sel_status  = (gb_addr == AW'(ADDR_STATUS));
    assign sel_ram     = (gb_addr[AW-1:RAM_AW] == RAM_BASE[AW-1:RAM_AW]);

    // Clear is applied on the writing edge and again while the stored
    // self-clearing bit is still high; clear beats increment.
    assign wr_ctrl    = gb_wen & sel_ctrl;
    assign cnt_clr    = (wr_ctrl & gb_wdata[CTRL_CLR_BIT]) | ctrl_q[CTRL_CLR_BIT];
    assign cnt_inc    = ctrl_q[CTRL_EN_BIT] & ~cnt_clr;
    assign cnt_wrap   = cnt_inc & (count_q == 32'hFFFF_FFFF);
    assign status_w1c = gb_wen & sel_status & gb_wdata[0];

    // Writable CSRs: SCRATCH, CTRL (bit 1 self-clears), STATUS overflow (set wins over W1C)
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (gb_wen && sel_scratch) begin
                scratch_q <= gb_wdata;
            end
            if (wr_ctrl) begin
                ctrl_q <= gb_wdata[7:0];
            end else begin
                ctrl_q[CTRL_CLR_BIT] <= 1'b0;
            end
            if (cnt_wrap) begin
                ovf_q <= 1'b1;
            end else if (status_w1c) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Free-running cycle counter gated by CTRL enable
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (cnt_inc) begin
            count_q <= count_q + 32'd1;
        end
    end

    // CSR read mux; RAM window and unmapped addresses contribute zero here
    always_comb begin
        rd_mux = '0;
        if (sel_id) begin
            rd_mux = DW'(ID_VALUE);
        end else if (sel_scratch) begin
            rd_mux = scratch_q;
        end else if (sel_ctrl) begin
            rd_mux = DW'(ctrl_q);
        end else if (sel_count) begin
            rd_mux = DW'(count_q);
        end else if (sel_status) begin
            rd_mux = DW'(ovf_q);
        end else if (sel_ram) begin
            rd_mux = '0;
        end
    end

    // Registered CSR read data, loaded only on a read strobe
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            csr_rdata_q <= '0;
        end else if (gb_rstb) begin
            csr_rdata_q <= rd_mux;
        end
    end

`ifdef GHOSTBUS_RAM_EN
    logic [DW-1:0] ram_rdata;
    logic          rd_ram_q;

    ghostbus_ram #(
        .AW (RAM_AW),
        .DW (DW)
    ) u_ram (
        .clk_i   (gb_clk),
        .we_i    (gb_wen & sel_ram),
        .re_i    (gb_rstb & sel_ram),
        .addr_i  (gb_addr[RAM_AW-1:0]),
        .wdata_i (gb_wdata),
        .rdata_o (ram_rdata)
    );

    // Remembers whether the last read targeted RAM, selecting the output source
    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            rd_ram_q <= 1'b0;
        end else if (gb_rstb) begin
            rd_ram_q <= sel_ram;
        end
    end

    assign gb_rdata = rd_ram_q ? ram_rdata : csr_rdata_q;
`else
    assign gb_rdata = csr_rdata_q;
`endif

endmodule

// File: tb/tb_ghostbus_top.sv
// tb_ghostbus_top: directed, self-checking bench for ghostbus_top.
module tb_ghostbus_top;
  import ghostbus_pkg::*;

  logic        gb_clk = 1'b0;
  logic        gb_rst = 1'b1;
  logic [23:0] gb_addr = '0;
  logic [31:0] gb_wdata = '0;
  logic        gb_wen = 1'b0;
  logic        gb_rstb = 1'b0;
  logic [31:0] gb_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  ghostbus_top dut (
    .gb_clk   (gb_clk),
    .gb_rst   (gb_rst),
    .gb_addr  (gb_addr),
    .gb_wdata (gb_wdata),
    .gb_wen   (gb_wen),
    .gb_rstb  (gb_rstb),
    .gb_rdata (gb_rdata)
  );

  // clock
  always #5 gb_clk = ~gb_clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // pop one expected read result and compare with the DUT output
  task automatic check_pop();
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(gb_rdata, e, t);
  endtask

  // one bus cycle driven at the negedge; a read pushes its expected result
  task automatic step(input logic w, input logic r, input logic [23:0] a,
                      input logic [31:0] d, input logic [31:0] e, input string tag);
    @(negedge gb_clk);
    if (exp_q.size() > 0) check_pop();
    gb_wen   = w;
    gb_rstb  = r;
    gb_addr  = a;
    gb_wdata = d;
    if (r) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 24'h0, 32'h0, 32'h0, "");
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 32'h0, "");
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] e, input string tag);
    step(1'b0, 1'b1, a, 32'h0, e, tag);
  endtask

  // read whose value is not known in advance (free-running counter)
  task automatic rd_raw(input logic [23:0] a, output logic [31:0] v);
    @(negedge gb_clk);
    if (exp_q.size() > 0) check_pop();
    gb_wen  = 1'b0;
    gb_rstb = 1'b1;
    gb_addr = a;
    @(negedge gb_clk);
    v = gb_rdata;
    gb_rstb = 1'b0;
  endtask

  initial begin
    logic [31:0] c1, c2;

    // reset
    @(posedge gb_clk);
    #1;
    check(gb_rdata, 32'h0, "reset_rdata");
    @(negedge gb_clk);
    gb_rst = 1'b0;

    // reset values of registers
    rd(ADDR_ID,      32'h47425553, "id_read");
    rd(ADDR_SCRATCH, 32'h0,        "scratch_reset");
    rd(ADDR_CTRL,    32'h0,        "ctrl_reset");
    rd(ADDR_COUNT,   32'h0,        "count_reset");
    rd(ADDR_STATUS,  32'h0,        "status_reset");

    // scratch write/read, ID is read-only
    wr(ADDR_SCRATCH, 32'hDEADBEEF);
    rd(ADDR_SCRATCH, 32'hDEADBEEF, "scratch_rw");
    wr(ADDR_ID, 32'h12345678);
    rd(ADDR_ID, 32'h47425553, "id_readonly");

    // read-before-write on a CSR, then the new value
    step(1'b1, 1'b1, ADDR_SCRATCH, 32'h11111111, 32'hDEADBEEF, "scratch_rbw");
    rd(ADDR_SCRATCH, 32'h11111111, "scratch_after_rbw");

    // CTRL keeps only 8 bits; COUNT ignores writes
    wr(ADDR_CTRL, 32'hFFFF_FF80);
    rd(ADDR_CTRL, 32'h0000_0080, "ctrl_trunc");
    wr(ADDR_COUNT, 32'h5555_5555);
    rd(ADDR_COUNT, 32'h0, "count_wr_ignored");

    // counter run: strobes five cycles apart differ by five
    wr(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 10; i++) idle();
    rd_raw(ADDR_COUNT, c1);
    idle();
    idle();
    idle();
    rd_raw(ADDR_COUNT, c2);
    check(c2 - c1, 32'd5, "count_delta5");
    check(32'(c1 > 32'd8), 32'd1, "count_running");

    // counter clear; self-clearing bit has dropped by the second read
    wr(ADDR_CTRL, 32'h2);
    rd(ADDR_COUNT, 32'h0, "count_cleared");
    rd(ADDR_CTRL,  32'h0, "ctrl_clr_selfclear");
    idle();
    rd(ADDR_COUNT, 32'h0, "count_stays_zero");

    // wrap and sticky overflow
    wr(ADDR_CTRL, 32'h1);
    @(negedge gb_clk);
    if (exp_q.size() > 0) check_pop();
    gb_wen = 1'b0;
    gb_rstb = 1'b0;
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    for (int i = 0; i < 4; i++) idle();
    rd_raw(ADDR_COUNT, c1);
    check(32'(c1 < 32'd16), 32'd1, "count_wrapped_small");
    rd(ADDR_STATUS, 32'h1, "status_ovf_set");
    rd(ADDR_STATUS, 32'h1, "status_ovf_sticky");
    wr(ADDR_STATUS, 32'h1);
    rd(ADDR_STATUS, 32'h0, "status_w1c");
    wr(ADDR_CTRL, 32'h0);

    // unmapped addresses
    wr(24'h00FFFF, 32'hFFFFFFFF);
    rd(24'h00FFFF, 32'h0, "unmapped_read");
    rd(24'h000005, 32'h0, "unmapped_above_csr");

`ifdef GHOSTBUS_RAM_EN
    for (int i = 0; i < 256; i++) wr(24'h000100 + 24'(i), 32'hA5A50000 + 32'(i));
    for (int i = 0; i < 256; i++) rd(24'h000100 + 24'(i), 32'hA5A50000 + 32'(i), "ram_readback");
    step(1'b1, 1'b1, 24'h000105, 32'hFFFFFFFF, 32'hA5A50005, "ram_rbw");
    rd(24'h000105, 32'hFFFFFFFF, "ram_after_rbw");
    rd(ADDR_ID, 32'h47425553, "id_after_ram");
`else
    wr(24'h000100, 32'h12345678);
    rd(24'h000100, 32'h0, "ram_window_unmapped");
    rd(24'h0001FF, 32'h0, "ram_window_top_unmapped");
`endif

    // reset asserted during a read
    wr(ADDR_SCRATCH, 32'hCAFEF00D);
    wr(ADDR_CTRL, 32'h81);
    rd(ADDR_SCRATCH, 32'hCAFEF00D, "scratch_before_rst");
    @(negedge gb_clk);
    if (exp_q.size() > 0) check_pop();
    gb_wen  = 1'b0;
    gb_rstb = 1'b1;
    gb_addr = ADDR_CTRL;
    #2;
    gb_rst = 1'b1;
    #1;
    check(gb_rdata, 32'h0, "rst_midread_immediate");
    @(posedge gb_clk);
    #1;
    check(gb_rdata, 32'h0, "rst_midread_held");
    @(negedge gb_clk);
    gb_rstb = 1'b0;
    gb_rst  = 1'b0;
    rd(ADDR_SCRATCH, 32'h0, "scratch_after_rst");
    rd(ADDR_CTRL,    32'h0, "ctrl_after_rst");
    rd(ADDR_COUNT,   32'h0, "count_after_rst");
`ifdef GHOSTBUS_RAM_EN
    rd(24'h000105, 32'hFFFFFFFF, "ram_kept_over_rst");
    rd(24'h000100, 32'hA5A50000, "ram_base_kept");
`endif
    idle();
    check(32'(exp_q.size()), 32'd0, "scoreboard_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ghostbus_top.md
# ghostbus_top

Top-level register block on the ghostbus local bus. It decodes a 24-bit word address into a small CSR set and an optional 256×32 RAM. Writes complete in one clock; reads return registered data one clock after the read strobe. It is the bus endpoint that host-side test sequences exercise.

## Interface
- AW, 24, bus address width (word addresses)
- DW, 32, bus data width
- RAM_AW, 8, RAM address width (2^RAM_AW words)
- ID_VALUE, 32'h47425553, constant returned by the ID register
- RAM_BASE, 24'h000100, RAM base address (aligned to 2^RAM_AW)

Ports:
- gb_clk  in  1  bus clock; all logic in this domain
- gb_rst  in  1  reset, asynchronous and active-high
- gb_addr  in  AW  word address
- gb_wdata  in  DW  write data
- gb_wen  in  1  write strobe, one-cycle qualified
- gb_rstb  in  1  read strobe, one-cycle qualified
- gb_rdata  out  DW  registered read data

## Operation
- Memory map, full AW-bit compare:
  - 0x000000 ID: read-only, returns ID_VALUE.
  - 0x000001 SCRATCH: read/write, 32 bits, reset 0.
  - 0x000002 CTRL: read/write, bits [7:0]. Bit 0 = counter enable, bit 1 = counter clear. Bit 1 self-clears the cycle after it is written. Reads return {24'b0, ctrl}. Reset 0.
  - 0x000003 COUNT: read-only, 32-bit counter. Increments every cycle while CTRL[0]=1. Wraps 0xFFFFFFFF→0. Writes ignored.
  - 0x000004 STATUS: bit 0 = sticky overflow, set on COUNT wrap. Write-1-to-clear. Other bits read 0.
  - RAM_BASE … RAM_BASE+2^RAM_AW−1: RAM, read/write, uninitialised, not reset.
- Unmapped addresses: reads return 0; writes are ignored.
- Write: on a gb_clk edge with gb_wen=1, the target register is updated with gb_wdata, truncated to the register width.
- Read: on a gb_clk edge with gb_rstb=1, gb_rdata loads the addressed value. gb_rdata holds that value until the next read.
- gb_wen and gb_rstb asserted together on the same address: the read returns the pre-write value (read-before-write); the write still takes effect.
- A counter clear (CTRL bit 1 written as 1) takes priority over an increment in the same cycle.
- An overflow set and a W1C in the same cycle: set wins.

## Timing
- Reset values: gb_rdata=0, SCRATCH=0, CTRL=0, COUNT=0, STATUS=0.
- Reset asserted mid-access: the access is aborted and all outputs and registers go to their reset values immediately. RAM contents are preserved.
- Write latency: the new value is visible to a read issued on the next cycle.
- Read latency: exactly 1 cycle. gb_rdata is valid on the cycle after the strobe edge.
- Back-to-back reads every cycle are supported. Each read result appears one cycle after its strobe.
- COUNT read value is the value present at the strobe edge.
- No handshake and no stall; the host must not assume ready/ack signals.

## Configuration
- GHOSTBUS_RAM_EN
  - Defined: the RAM region is implemented as described above.
  - Undefined: no RAM is instantiated. The RAM address range behaves as unmapped (reads 0, writes ignored).

## Structure
- Shared package ghostbus_pkg holds:
  - address constants ADDR_ID, ADDR_SCRATCH, ADDR_CTRL, ADDR_COUNT, ADDR_STATUS and RAM_BASE;
  - the default ID_VALUE;
  - CTRL bit indices.
- One sub-module, ghostbus_ram: single-port synchronous RAM, 2^RAM_AW×DW, one write port and one 1-cycle registered read port with read-before-write. It is instantiated only under GHOSTBUS_RAM_EN.
- Top-level logic: address decode, CSR registers, counter, and a read mux into the gb_rdata register.

## Test plan
- Reset then read 0x000000 → gb_rdata=0x47425553 one cycle after the strobe. Read 0x000001 → 0.
- Write 0xDEADBEEF to 0x000001, then read it → 0xDEADBEEF. Write 0x12345678 to 0x000000, then read it → still 0x47425553.
- Write 0x1 to CTRL and wait 10 cycles; two reads of COUNT 5 cycles apart differ by 5. Write 0x2 to CTRL → COUNT reads 0 and CTRL reads 0x0.
- Force COUNT near 0xFFFFFFFE with CTRL=1 → COUNT wraps to small values and STATUS reads 0x1. Write 0x1 to STATUS → STATUS reads 0x0.
- With GHOSTBUS_RAM_EN: write 0xA5A50000+i to 0x000100+i for i=0..255, then read all → matching data. Simultaneous wen/rstb on 0x000105 with data 0xFFFFFFFF → the read returns 0xA5A50005 and a later read returns 0xFFFFFFFF.
- Read 0x00FFFF (unmapped) → 0. Assert gb_rst during a read → gb_rdata=0 immediately; SCRATCH and CTRL read 0 afterward.
